// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: holds the PLL in reset, waits for lock with timeout/retry,
// qualifies lock stability before releasing sys_rst. Optional retry counter: PLL_SUP_RETRY_CNT_EN.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost
`ifdef PLL_SUP_RETRY_CNT_EN
    ,
    output logic [7:0] retry_cnt
`endif
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LOAD  = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_RUN
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lk_meta, lk_s;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_RST: begin
                if (cnt == '0) begin
                    state_nx = S_WAIT;
                    cnt_nx   = TO_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_WAIT: begin
                // lock seen on the timeout cycle still counts as lock
                if (lk_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = ST_LOAD;
                end else if (cnt == '0) begin
                    state_nx = S_RST;
                    cnt_nx   = RST_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk_s) begin
                    state_nx = S_WAIT;
                    cnt_nx   = TO_LOAD;
                end else if (cnt == '0) begin
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    state_nx = S_RST;
                    cnt_nx   = RST_LOAD;
                end
            end
            default: begin
                state_nx = S_RST;
                cnt_nx   = RST_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RST;
            cnt       <= RST_LOAD;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pll_rst   <= (state_nx == S_RST);
            sys_rst   <= (state_nx != S_RUN);
            ready     <= (state_nx == S_RUN);
            lock_lost <= (state == S_RUN) && !lk_s;
        end
    end

`ifdef PLL_SUP_RETRY_CNT_EN
    logic retry;
    assign retry = ((state == S_WAIT) && !lk_s && (cnt == '0)) ||
                   ((state == S_RUN) && !lk_s);

    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_cnt <= 8'd0;
        end else if (retry && (retry_cnt != 8'hFF)) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end
`endif

endmodule
